// File: rtl/pio_write_arbiter_if.sv
// Avalon-MM bus to a single 32-bit output PIO slave (address 0, zero wait states,
// combinational readdata). The master side is driven by pio_write_arbiter.
interface pio_write_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_write_arbiter.sv
// Round-robin arbiter that shares one output PIO among NUM_REQ requesters; every
// granted value is written, read back and retried up to MAX_RETRY times on mismatch.
module pio_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_RETRY = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [NUM_REQ-1:0]         err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [DATA_W-1:0]          last_value,
  pio_write_arbiter_if.master        pio
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_id_q, grant_id_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] last_value_q, last_value_d;
  logic [2:0]        retry_cnt_q, retry_cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] err_q, err_d;

  logic              found;
  logic [GW-1:0]     winner;
  logic [DATA_W-1:0] sel_data;
  logic [NUM_REQ-1:0] grant_onehot;
  logic              err_flag;

  // Rotate the request vector so bit 0 is the requester just after last_grant,
  // then the lowest set bit is the fair winner.
  always_comb begin : rr_search
    logic [2*NUM_REQ-1:0] rotated;
    int pos;
    rotated = {req, req} >> (int'(last_grant_q) + 1);
    found   = 1'b0;
    pos     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found = 1'b1;
        pos   = int'(last_grant_q) + 1 + i;
      end
    end
    if (pos >= NUM_REQ) pos = pos - NUM_REQ;
    winner = GW'(pos);
  end

  always_comb begin
    sel_data     = '0;
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == winner) sel_data = req_data[i*DATA_W +: DATA_W];
      grant_onehot[i] = (GW'(i) == grant_id_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    wdata_d      = wdata_q;
    last_value_d = last_value_q;
    retry_cnt_d  = retry_cnt_q;
    ack_d        = '0;
    err_d        = '0;
    err_flag     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d  = winner;
          wdata_d     = sel_data;
          retry_cnt_d = '0;
          state_d     = WRITE;
        end
      end
      WRITE: state_d = VERIFY;
      VERIFY: begin
        if (pio.readdata == wdata_q) begin
          state_d = DONE;
        end else if (retry_cnt_q < RETRY_LIMIT) begin
          retry_cnt_d = retry_cnt_q + 3'd1;
          state_d     = WRITE;
        end else begin
          err_flag = 1'b1;
          state_d  = DONE;
        end
        // ack/err are registered on entry so they are high for exactly the DONE cycle.
        if (state_d == DONE) begin
          ack_d = grant_onehot;
          err_d = err_flag ? grant_onehot : '0;
          if (!err_flag) last_value_d = wdata_q;
        end
      end
      DONE: begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      wdata_q      <= '0;
      last_value_q <= '0;
      retry_cnt_q  <= '0;
      ack_q        <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      wdata_q      <= wdata_d;
      last_value_q <= last_value_d;
      retry_cnt_q  <= retry_cnt_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    pio.chipselect = 1'b0;
    pio.write_n    = 1'b1;
    pio.writedata  = '0;
    case (state_q)
      WRITE: begin
        pio.chipselect = 1'b1;
        pio.write_n    = 1'b0;
        pio.writedata  = wdata_q;
      end
      VERIFY: pio.chipselect = 1'b1;
      default: ;
    endcase
  end

  assign pio.address = 2'b00;
  assign ack         = ack_q;
  assign err         = err_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_id_q;
  assign last_value  = last_value_q;

endmodule
